mem_ctrl: RTL and testbench

- Byte-serial memory controller between the core's requesters and the external 8-bit RAM/IO bus.
- Requesters are the instruction-fetch unit (word reads) and the load/store unit (1/2/4-byte reads and writes).
- Arbitrates between the two requesters and splits each access into little-endian byte transactions on mem_a/mem_dout/mem_wr.
- Reassembles read bytes into a 32-bit response.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/mem_byte_seq.sv | 65 ++++++
 rtl/mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory controller slice: FSM state
// encoding, request size codes, requester identifiers and the IO window base.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [31:0] IO_BASE_ADDR = 32'h0003_0000;

  // Size code 3 is illegal and falls into the word case.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: byte counter, address generation, store-data byte select
// and little-endian reassembly of read bytes from mem_din.
module mem_byte_seq
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [31:0]       start_wdata,
  input  logic              advance,
  input  logic              capture,
  input  logic              drive_a,
  input  logic              drive_d,
  input  logic [7:0]        mem_din,
  output logic [2:0]        cnt,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout
);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] last_a;
  logic [31:0]       wbuf;
  logic [7:0]        last_dout;
  logic [1:0]        wr_idx;
  logic [1:0]        cap_idx;

  assign cur_addr = base + ADDR_W'(cnt);
  assign wr_idx   = cnt[1:0];
  assign cap_idx  = cnt[1:0] - 2'd1;

  // While frozen the bus keeps the last driven address, so the RAM keeps
  // returning the byte that is due for capture once the stall ends.
  assign mem_a    = drive_a ? cur_addr : last_a;
  assign mem_dout = drive_d ? wbuf[8*wr_idx +: 8] : last_dout;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      base      <= '0;
      last_a    <= '0;
      wbuf      <= '0;
      last_dout <= '0;
      cnt       <= '0;
      rdata     <= '0;
    end else if (rdy_in) begin
      last_a    <= mem_a;
      last_dout <= mem_dout;
      if (start) begin
        base  <= start_addr;
        wbuf  <= start_wdata;
        cnt   <= '0;
        rdata <= '0;
      end else begin
        if (advance) cnt <= cnt + 3'd1;
        if (capture) rdata[8*cap_idx +: 8] <= mem_din;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests and
// runs them as byte transactions. Optional IO guard: MEM_CTRL_IO_GUARD_EN.
module mem_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W  = 32,
  parameter logic [ADDR_W-1:0]  IO_BASE = ADDR_W'(IO_BASE_ADDR)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_data,
  input  logic              ls_req_valid,
  input  logic              ls_req_wr,
  input  logic [1:0]        ls_req_size,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [31:0]       ls_req_wdata,
  output logic              ls_resp_valid,
  output logic [31:0]       ls_resp_rdata,
  input  logic              flush,
  output logic              busy
);

  state_t            state, state_nx;
  owner_t            owner;
  logic              req_wr;
  logic [2:0]        req_n;
  logic [2:0]        last_idx;
  logic              kill;
  logic              accept;
  logic              sel_ls;
  logic [ADDR_W-1:0] start_addr;
  logic              blocked;
  logic              keep_io;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       rdata;
  logic              seq_start, seq_adv, seq_cap, seq_drive_a, seq_drive_d;
  logic              resp;

  assign sel_ls     = ls_req_valid;
  assign start_addr = sel_ls ? ls_req_addr : if_req_addr;
  assign accept     = (state == IDLE) && !flush && (if_req_valid || ls_req_valid);
  assign last_idx   = req_n - 3'd1;

`ifdef MEM_CTRL_IO_GUARD_EN
  logic io_rd;

  always_ff @(posedge clk_in) begin
    if (rst_in)                 io_rd <= 1'b0;
    else if (rdy_in && accept) io_rd <= (start_addr >= IO_BASE);
  end

  assign blocked = io_buffer_full && (cur_addr >= IO_BASE);
  assign keep_io = io_rd;
`else
  logic [ADDR_W:0] unused_io;

  assign unused_io = {io_buffer_full, IO_BASE};
  assign blocked   = 1'b0;
  assign keep_io   = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in)      state <= IDLE;
    else if (rdy_in) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = (sel_ls && ls_req_wr) ? WRITE : READ;
      READ: begin
        if (flush && !keep_io) state_nx = IDLE;
        else if (cnt == req_n) state_nx = DONE;
      end
      WRITE: if (!blocked && cnt == last_idx) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    mem_wr      = rdy_in && (state == WRITE) && !blocked;
    seq_start   = rdy_in && accept;
    seq_drive_a = rdy_in && (((state == READ) && (cnt < req_n)) || (state == WRITE));
    seq_drive_d = rdy_in && (state == WRITE);
    seq_adv     = ((state == READ) && (cnt < req_n)) || ((state == WRITE) && !blocked);
    seq_cap     = (state == READ) && (cnt != 3'd0);
    // A flush landing on a read's DONE cycle still cancels its response.
    resp        = rdy_in && (state == DONE) && !kill && !(flush && !req_wr);
    if_resp_valid = resp && (owner == OWN_IF);
    ls_resp_valid = resp && (owner == OWN_LS);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      owner  <= OWN_IF;
      req_wr <= 1'b0;
      req_n  <= '0;
      kill   <= 1'b0;
    end else if (rdy_in) begin
      if (accept) begin
        owner  <= sel_ls ? OWN_LS : OWN_IF;
        req_wr <= sel_ls && ls_req_wr;
        req_n  <= sel_ls ? size_bytes(ls_req_size) : 3'd4;
        kill   <= 1'b0;
      end else if ((state == READ) && flush) begin
        kill <= 1'b1;
      end
    end
  end

  assign if_resp_data  = rdata;
  assign ls_resp_rdata = rdata;

  mem_byte_seq #(
    .ADDR_W(ADDR_W)
  ) u_seq (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .start       (seq_start),
    .start_addr  (start_addr),
    .start_wdata (ls_req_wdata),
    .advance     (seq_adv),
    .capture     (seq_cap),
    .drive_a     (seq_drive_a),
    .drive_d     (seq_drive_d),
    .mem_din     (mem_din),
    .cnt         (cnt),
    .cur_addr    (cur_addr),
    .rdata       (rdata),
    .mem_a       (mem_a),
    .mem_dout    (mem_dout)
  );

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests against a byte RAM model,
// with response and bus-write monitors popping hand-computed expectations.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, mem_wr, io_buffer_full, flush, busy;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        if_req_valid, if_resp_valid, ls_req_valid, ls_req_wr, ls_resp_valid;
  logic [31:0] if_req_addr, if_resp_data, ls_req_addr, ls_req_wdata, ls_resp_rdata;
  logic [1:0]  ls_req_size;

  always #5 clk_in = ~clk_in;

  mem_ctrl #(.ADDR_W(32), .IO_BASE(32'h0003_0000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_wr(ls_req_wr), .ls_req_size(ls_req_size),
    .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
    .ls_resp_valid(ls_resp_valid), .ls_resp_rdata(ls_resp_rdata),
    .flush(flush), .busy(busy)
  );

  logic [7:0] ram [0:65535];
  always @(posedge clk_in) mem_din <= ram[mem_a[15:0]];

  typedef struct packed { logic own_ls; logic has_data; logic [31:0] data; } resp_t;
  typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
  resp_t exp_q[$];
  wr_t   wexp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin : resp_mon
    resp_t e;
    if (if_resp_valid || ls_resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", {30'b0, if_resp_valid, ls_resp_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_owner", {30'b0, if_resp_valid, ls_resp_valid}, e.own_ls ? 32'd1 : 32'd2);
        if (e.has_data) chk("resp_data", e.own_ls ? ls_resp_rdata : if_resp_data, e.data);
      end
    end
  end

  always @(negedge clk_in) begin : wr_mon
    wr_t w;
    if (mem_wr) begin
      if (wexp_q.size() == 0) begin
        chk("wr_unexpected", {31'b0, mem_wr}, 32'd0);
      end else begin
        w = wexp_q.pop_front();
        chk("wr_addr", mem_a, w.a);
        chk("wr_data", {24'b0, mem_dout}, {24'b0, w.d});
      end
`ifdef MEM_CTRL_IO_GUARD_EN
      if (mem_a >= 32'h0003_0000) chk("io_wr_while_full", {31'b0, io_buffer_full}, 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Counts rising edges from request presentation to the owner's pulse.
  task automatic wait_resp(input logic own_ls, input int stall_at, input int stall_len,
                           output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk_in);
      n++;
      #1;
      if (stall_at != 0 && n == stall_at) rdy_in = 1'b0;
      if (stall_at != 0 && n == stall_at + stall_len) rdy_in = 1'b1;
      @(negedge clk_in);
      if (!rdy_in) chk("stall_mem_wr", {31'b0, mem_wr}, 32'd0);
      if (own_ls ? ls_resp_valid : if_resp_valid) return;
    end
    chk("resp_timeout", 32'd1, 32'd0);
    n = -1;
  endtask

  task automatic ls_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
    ls_req_valid = 1'b1;
    ls_req_wr    = wr;
    ls_req_size  = size;
    ls_req_addr  = addr;
    ls_req_wdata = wdata;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
    ram[16'h0040] = 8'h34; ram[16'h0041] = 8'h12;
    ram[16'hFFFF] = 8'hAB; ram[16'h0000] = 8'hCD;
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0;
    ls_req_valid = 1'b0; ls_req_wr = 1'b0; ls_req_size = 2'd0; ls_req_addr = '0; ls_req_wdata = '0;

    tick(); tick();
    @(negedge clk_in);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", {24'b0, mem_dout}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_if_valid", {31'b0, if_resp_valid}, 32'd0);
    chk("rst_ls_valid", {31'b0, ls_resp_valid}, 32'd0);
    chk("rst_if_data", if_resp_data, 32'd0);
    chk("rst_ls_data", ls_resp_rdata, 32'd0);
    tick();
    rst_in = 1'b0;
    tick();

    // Instruction fetch, word at 0x1000.
    if_req_addr = 32'h1000; if_req_valid = 1'b1;
    exp_q.push_back('{own_ls: 1'b0, has_data: 1'b1, data: 32'h0000_0513});
    wait_resp(1'b0, 0, 0, lat);
    chk("if_latency", lat, 32'd6);
    tick(); if_req_valid = 1'b0;

    // Byte store: only the low byte goes out.
    ls_req(1'b1, 2'd0, 32'h20, 32'hAABB_CCDD);
    wexp_q.push_back('{a: 32'h20, d: 8'hDD});
    exp_q.push_back('{own_ls: 1'b1, has_data: 1'b0, data: 32'h0});
    wait_resp(1'b1, 0, 0, lat);
    chk("st_b_latency", lat, 32'd2);
    tick(); ls_req_valid = 1'b0;

    // Both requesters valid: LS half load first, then the fetch.
    ls_req(1'b0, 2'd1, 32'h40, 32'h0);
    if_req_addr = 32'h1000; if_req_valid = 1'b1;
    exp_q.push_back('{own_ls: 1'b1, has_data: 1'b1, data: 32'h0000_1234});
    exp_q.push_back('{own_ls: 1'b0, has_data: 1'b1, data: 32'h0000_0513});
    wait_resp(1'b1, 0, 0, lat);
    chk("arb_ls_latency", lat, 32'd4);
    tick(); ls_req_valid = 1'b0;
    wait_resp(1'b0, 0, 0, lat);
    chk("arb_if_latency", lat, 32'd6);
    tick(); if_req_valid = 1'b0;

    // Flush on the second cycle of a fetch.
    if_req_addr = 32'h1000; if_req_valid = 1'b1;
    tick(); tick();
    flush = 1'b1; if_req_valid = 1'b0;
    tick();
    flush = 1'b0;
    @(negedge clk_in);
    chk("flush_if_idle", {31'b0, busy}, 32'd0);
    repeat (8) tick();

    // Flush during a word store: all four bytes still go out.
    ls_req(1'b1, 2'd2, 32'h90, 32'h8877_6655);
    wexp_q.push_back('{a: 32'h90, d: 8'h55});
    wexp_q.push_back('{a: 32'h91, d: 8'h66});
    wexp_q.push_back('{a: 32'h92, d: 8'h77});
    wexp_q.push_back('{a: 32'h93, d: 8'h88});
    exp_q.push_back('{own_ls: 1'b1, has_data: 1'b0, data: 32'h0});
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_resp(1'b1, 0, 0, lat);
    tick(); ls_req_valid = 1'b0;

    // Three-cycle stall in the middle of a word fetch.
    if_req_addr = 32'h1000; if_req_valid = 1'b1;
    exp_q.push_back('{own_ls: 1'b0, has_data: 1'b1, data: 32'h0000_0513});
    wait_resp(1'b0, 3, 3, lat);
    chk("stall_latency", lat, 32'd9);
    tick(); if_req_valid = 1'b0;

    // Illegal size 3 behaves as a word load.
    ls_req(1'b0, 2'd3, 32'h1000, 32'h0);
    exp_q.push_back('{own_ls: 1'b1, has_data: 1'b1, data: 32'h0000_0513});
    wait_resp(1'b1, 0, 0, lat);
    chk("sz3_latency", lat, 32'd6);
    tick(); ls_req_valid = 1'b0;

    // Half load crossing the top of the address space wraps to 0.
    ls_req(1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0);
    exp_q.push_back('{own_ls: 1'b1, has_data: 1'b1, data: 32'h0000_CDAB});
    wait_resp(1'b1, 0, 0, lat);
    tick(); ls_req_valid = 1'b0;

    // Byte load is zero-extended.
    ls_req(1'b0, 2'd0, 32'h41, 32'h0);
    exp_q.push_back('{own_ls: 1'b1, has_data: 1'b1, data: 32'h0000_0012});
    wait_resp(1'b1, 0, 0, lat);
    tick(); ls_req_valid = 1'b0;

    // Reset while byte 2 of a word store is on the bus.
    ls_req(1'b1, 2'd2, 32'h80, 32'h4433_2211);
    wexp_q.push_back('{a: 32'h80, d: 8'h11});
    wexp_q.push_back('{a: 32'h81, d: 8'h22});
    wexp_q.push_back('{a: 32'h82, d: 8'h33});
    tick(); tick(); tick();
    rst_in = 1'b1; ls_req_valid = 1'b0;
    tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_mid_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    repeat (5) tick();

`ifdef MEM_CTRL_IO_GUARD_EN
    // IO store held off while the UART buffer is full.
    io_buffer_full = 1'b1;
    ls_req(1'b1, 2'd0, 32'h0003_0000, 32'h0000_005A);
    wexp_q.push_back('{a: 32'h0003_0000, d: 8'h5A});
    exp_q.push_back('{own_ls: 1'b1, has_data: 1'b0, data: 32'h0});
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk_in);
      chk("io_hold_wr", {31'b0, mem_wr}, 32'd0);
    end
    tick();
    io_buffer_full = 1'b0;
    @(negedge clk_in);
    chk("io_release_wr", {31'b0, mem_wr}, 32'd1);
    wait_resp(1'b1, 0, 0, lat);
    chk("io_release_latency", lat, 32'd1);
    tick(); ls_req_valid = 1'b0;
`endif

    repeat (4) tick();
    chk("resp_queue_drained", exp_q.size(), 32'd0);
    chk("write_queue_drained", wexp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
